// File: rtl/uart_rx_fifo.sv
// Buffers bytes from a UART receiver: detects frame ends on the idle rise, rejects short lows, queues bytes in a FWFT FIFO.
// Push visible one cycle after frame end; bytes arriving while full (without a same-cycle pop) are dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH          = 16,
    parameter int MIN_FRAME_CLKS = 83328
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic                     enable_i,
    input  logic                     rx_ready_i,
    input  logic [7:0]               rx_data_i,
    output logic                     rx_en_o,
    output logic [7:0]               m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clear_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MIN_FRAME_CLKS + 1);
    localparam logic [LW-1:0] LOW_MAX  = LW'(MIN_FRAME_CLKS);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [LW-1:0] low_cnt;
    logic          rdy_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];

    logic fe;
    logic push_req;
    logic full;
    logic pop;
    logic push;

    always_comb begin
        fe       = rx_ready_i & ~rdy_q;
        push_req = fe & (low_cnt == LOW_MAX);
        full     = (count_o == FULL_CNT);
        pop      = m_valid_o & m_ready_i;
        // A same-cycle pop frees the slot the full FIFO would otherwise refuse.
        push     = push_req & (~full | pop);
    end

    assign rx_en_o   = enable_i;
    assign m_valid_o = (count_o != '0);
    assign m_data_o  = mem[rd_ptr];

    // Receiver tracking is independent of clear so an in-flight frame survives a flush.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            low_cnt <= '0;
            rdy_q   <= 1'b1;
        end else begin
            rdy_q <= rx_ready_i;
            if (rx_ready_i)
                low_cnt <= '0;
            else if (low_cnt != LOW_MAX)
                low_cnt <= low_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_data_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count_o <= count_o + (AW + 1)'(1);
            else if (pop && !push)
                count_o <= count_o - (AW + 1)'(1);
            if (push_req && full && !pop)
                overflow_o <= 1'b1;
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It watches the receiver's idle/ready indication and detects completed frames. Each completed byte is pushed into a DEPTH-entry FIFO and presented to the system on a valid/ready stream interface. Aborted frames (false starts) are rejected, and bytes that arrive while the FIFO is full are dropped and flagged.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `MIN_FRAME_CLKS`, 83328: minimum consecutive cycles `rx_ready_i` must be low for a low period to count as a real frame (8 × 10416 clocks/bit at 100 MHz / 9600 baud).
- `clk_i` in 1: single clock; all logic on its rising edge.
- `nreset_i` in 1: reset, synchronous, active-low.
- `enable_i` in 1: software receive enable.
- `rx_ready_i` in 1: receiver idle indication; 1 = idle, 0 = frame in progress.
- `rx_data_i` in 8: receiver data byte; stable while `rx_ready_i`=1.
- `rx_en_o` out 1: start-enable to the receiver; equals `enable_i` (combinational).
- `m_data_o` out 8: head-of-FIFO byte, first-word fall-through.
- `m_valid_o` out 1: FIFO non-empty.
- `m_ready_i` in 1: consumer accepts `m_data_o` when `m_valid_o`=1.
- `count_o` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow_o` out 1: sticky flag, byte dropped because FIFO full.
- `clear_i` in 1: synchronous flush; empties FIFO and clears `overflow_o`.

## Operation
- **Reset values:** `m_valid_o`=0, `count_o`=0, `overflow_o`=0, `m_data_o`=8'h00. Read and write pointers are 0 and the memory is zeroed. The internal previous-ready register `rdy_q` resets to 1, so the receiver's post-reset idle is not seen as an edge.
- **Low-time counter `low_cnt`:**
  - Width $clog2(MIN_FRAME_CLKS+1).
  - Cleared while `rx_ready_i`=1.
  - Increments while `rx_ready_i`=0; saturates at MIN_FRAME_CLKS with no wrap.
- **Frame-end event `fe`:** `rx_ready_i`=1 AND `rdy_q`=0 (rising edge).
  - `fe` with `low_cnt` ≥ MIN_FRAME_CLKS is a push request of `rx_data_i`.
  - `fe` with `low_cnt` < MIN_FRAME_CLKS is a false start; it is ignored and nothing is pushed.
- **Push:**
  - FIFO not full: write `mem[wr_ptr]` and increment `wr_ptr` modulo DEPTH.
  - FIFO full and no pop in the same cycle: discard the byte and set `overflow_o`.
  - FIFO full and a pop in the same cycle: the push is accepted and `count_o` stays DEPTH.
- **Pop:** occurs when `m_valid_o` AND `m_ready_i`. `rd_ptr` increments modulo DEPTH.
- **Occupancy:**
  - `count_o` changes by +1 on push only, −1 on pop only, and 0 on both.
  - `m_valid_o` = (`count_o` ≠ 0).
  - `m_data_o` = `mem[rd_ptr]`.
- **Pointers:** both are $clog2(DEPTH) bits and wrap naturally.
- **Clear:**
  - `clear_i`=1 has priority over push and pop in the same cycle: pointers go to 0, `count_o` to 0, `overflow_o` to 0, and a coincident push is lost.
  - `low_cnt` and `rdy_q` continue to track the receiver, so a frame in flight during clear is still captured afterwards.
- **Disable:** `enable_i`=0 has no effect on the FIFO. A frame already in progress is still captured at its end.

## Timing
- Push latency: `fe` in cycle N (push committed at the N edge) gives `m_valid_o`=1 and `count_o` updated in cycle N+1.
- Pop: the handshake in cycle N gives the next entry (or `m_valid_o`=0) in cycle N+1. Back-to-back pops at one byte per cycle are supported.
- `overflow_o` asserts in the cycle after the dropped `fe`.
- Reset mid-frame: state returns to its reset values. Because `rdy_q`=1 after reset, the receiver's subsequent ready rise is only captured if it follows a fresh low period of ≥ MIN_FRAME_CLKS.
- `rx_en_o` has zero latency, combinational from `enable_i`.

## Test plan
1. **Single frame.** After reset, hold `rx_ready_i`=0 for 104160 cycles, then 1 with `rx_data_i`=8'hA5.
   - Required: one cycle later `m_valid_o`=1, `m_data_o`=8'hA5, `count_o`=1.
   - Then `m_ready_i`=1 for one cycle gives `m_valid_o`=0.
2. **False start.** `rx_ready_i` low for 5208 cycles, then high with `rx_data_i`=8'h3C.
   - Required: `count_o` stays 0 and `m_valid_o` stays 0.
3. **Fill and overflow.** Push 16 frames 8'h00..8'h0F with `m_ready_i`=0, then a 17th frame 8'hFF.
   - Required: `count_o`=16 and `overflow_o`=1.
   - Draining yields 8'h00..8'h0F in order, and 8'hFF never appears.
4. **Full with simultaneous pop.** With the FIFO full, the frame-end of 8'h77 coincides with `m_ready_i`=1.
   - Required: `count_o` stays 16, `overflow_o`=0, and 8'h77 is the last byte drained.
5. **Clear.** Start with 3 entries and `overflow_o`=1, then pulse `clear_i` for one cycle.
   - Required: the next cycle shows `count_o`=0, `m_valid_o`=0, `overflow_o`=0.
   - A subsequent valid frame 8'h5A is the only byte read.
6. **Pointer wrap.** Run 40 frames with `m_ready_i`=1 throughout.
   - Required: each byte is read exactly once, in order, and `count_o` never exceeds 1.
